// File: rtl/nixie_display_arbiter.sv
// ---------------------------------------------------------------------------
// nixie_display_arbiter
//
// Shares one 2-digit multiplexed nixie display among four requesters.
// A round-robin arbiter with a minimum hold time chooses the owner and
// latches that owner's byte into a shadow register. A scan FSM lights the
// low and high hex digits in turn, with blank gaps between them to stop
// ghosting. The shadow byte is copied into the frame register only at the
// start of a frame, so a frame never shows a mix of old and new digits.
//
// Ports:
//   i_clk        system clock
//   i_rst        asynchronous reset, active low
//   i_req[3:0]   request level, bit n = requester n
//   i_data[31:0] requester n value on i_data[8n+7:8n]
//   o_grant[3:0] one-hot 1-cycle pulse on grant or re-latch
//   o_owner[1:0] index of the current owner
//   o_nixieTube  segments {g,f,e,d,c,b,a}, 1 = lit
//   o_sel        digit select, 0 = low nibble, 1 = high nibble
//
// Optional feature macro: NIXIE_LEADING_ZERO_BLANK_EN
//   When defined, the high digit stays dark if the high nibble is zero.
// ---------------------------------------------------------------------------
module nixie_display_arbiter #(
  parameter int unsigned DWELL_CYCLES = 50000,
  parameter int unsigned BLANK_CYCLES = 500,
  parameter int unsigned HOLD_CYCLES  = 50000000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [3:0]  i_req,
  input  logic [31:0] i_data,
  output logic [3:0]  o_grant,
  output logic [1:0]  o_owner,
  output logic [6:0]  o_nixieTube,
  output logic        o_sel
);

  localparam int unsigned SCAN_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int unsigned SCAN_W   = $clog2(SCAN_MAX + 1);
  localparam int unsigned HOLD_W   = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {
    S_DIG0   = 2'd0,
    S_BLANK0 = 2'd1,
    S_DIG1   = 2'd2,
    S_BLANK1 = 2'd3
  } scan_state_e;

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  function automatic logic [6:0] hi_seg(input logic [3:0] nib);
`ifdef NIXIE_LEADING_ZERO_BLANK_EN
    return (nib == 4'h0) ? 7'h00 : hex7(nib);
`else
    return hex7(nib);
`endif
  endfunction

  // Arbiter state
  logic [3:0]        grant_q, grant_d;
  logic [1:0]        owner_q, owner_d;
  logic              owner_vld_q, owner_vld_d;
  logic [7:0]        shadow_q, shadow_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  // Scan state
  scan_state_e       state_q, state_d;
  logic [SCAN_W-1:0] cnt_q, cnt_d;
  logic [7:0]        frame_q, frame_d;
  logic              sel_q, sel_d;
  logic [6:0]        seg_q, seg_d;

  // Arbitration decision
  logic       win;
  logic [1:0] win_idx;
  logic [1:0] start_idx;
  logic [1:0] scan_idx;

  always_comb begin
    win       = 1'b0;
    win_idx   = owner_q;
    scan_idx  = 2'd0;
    // Searching from owner+1 naturally puts a still-requesting owner last.
    start_idx = owner_vld_q ? (owner_q + 2'd1) : 2'd0;
    if (hold_q == '0) begin
      for (int k = 0; k < 4; k++) begin
        scan_idx = start_idx + 2'(k);
        if (!win && i_req[scan_idx]) begin
          win     = 1'b1;
          win_idx = scan_idx;
        end
      end
    end else if (i_req[owner_q]) begin
      // While the hold runs only the owner may refresh its value.
      win     = 1'b1;
      win_idx = owner_q;
    end
  end

  always_comb begin
    grant_d     = '0;
    owner_d     = owner_q;
    owner_vld_d = owner_vld_q;
    shadow_d    = shadow_q;
    hold_d      = hold_q;
    if (win) begin
      grant_d     = 4'b0001 << win_idx;
      owner_d     = win_idx;
      owner_vld_d = 1'b1;
      shadow_d    = i_data[{win_idx, 3'b000} +: 8];
      hold_d      = HOLD_W'(HOLD_CYCLES);
    end else if (hold_q != '0) begin
      hold_d = hold_q - HOLD_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      grant_q     <= '0;
      owner_q     <= '0;
      owner_vld_q <= 1'b0;
      shadow_q    <= '0;
      hold_q      <= '0;
    end else begin
      grant_q     <= grant_d;
      owner_q     <= owner_d;
      owner_vld_q <= owner_vld_d;
      shadow_q    <= shadow_d;
      hold_q      <= hold_d;
    end
  end

  // Scan FSM: segments and select are registered and computed for the state
  // being entered, so they change together on the first cycle of a digit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    sel_d   = sel_q;
    seg_d   = seg_q;
    if (cnt_q != '0) begin
      cnt_d = cnt_q - SCAN_W'(1);
    end else begin
      case (state_q)
        S_DIG0: begin
          state_d = S_BLANK0;
          cnt_d   = SCAN_W'(BLANK_CYCLES - 1);
          seg_d   = 7'h00;
        end
        S_BLANK0: begin
          state_d = S_DIG1;
          cnt_d   = SCAN_W'(DWELL_CYCLES - 1);
          sel_d   = 1'b1;
          seg_d   = hi_seg(frame_q[7:4]);
        end
        S_DIG1: begin
          state_d = S_BLANK1;
          cnt_d   = SCAN_W'(BLANK_CYCLES - 1);
          seg_d   = 7'h00;
        end
        default: begin
          // Frame start: the only point where a new value becomes visible.
          state_d = S_DIG0;
          cnt_d   = SCAN_W'(DWELL_CYCLES - 1);
          frame_d = shadow_q;
          sel_d   = 1'b0;
          seg_d   = hex7(shadow_q[3:0]);
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= S_BLANK1;
      cnt_q   <= '0;
      frame_q <= '0;
      sel_q   <= 1'b0;
      seg_q   <= 7'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      sel_q   <= sel_d;
      seg_q   <= seg_d;
    end
  end

  assign o_grant     = grant_q;
  assign o_owner     = owner_q;
  assign o_nixieTube = seg_q;
  assign o_sel       = sel_q;

endmodule

// File: tb/tb_nixie_display_arbiter.sv
module tb_nixie_display_arbiter;

  localparam int DWELL = 8;
  localparam int BLANK = 2;
  localparam int HOLD  = 20;
  localparam int FRAME = 2 * (DWELL + BLANK);
`ifdef NIXIE_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] HI_ZERO = 7'h00;
`else
  localparam logic [6:0] HI_ZERO = 7'h3F;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic [3:0]  i_req = 4'b0;
  logic [31:0] i_data = 32'h0;
  logic [3:0]  o_grant;
  logic [1:0]  o_owner;
  logic [6:0]  o_nixieTube;
  logic        o_sel;

  always #5 i_clk = ~i_clk;

  nixie_display_arbiter #(
    .DWELL_CYCLES(DWELL),
    .BLANK_CYCLES(BLANK),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_req      (i_req),
    .i_data     (i_data),
    .o_grant    (o_grant),
    .o_owner    (o_owner),
    .o_nixieTube(o_nixieTube),
    .o_sel      (o_sel)
  );

  int checks = 0;
  int passes = 0;
  int tb_cyc = 0;

  always @(posedge i_clk) tb_cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
  endtask

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return tbl[n];
  endfunction

  // Behavioural model: pos_m counts clock edges since reset release; the
  // display is a pure function of the position within the frame.
  int         pos_m;
  logic [3:0] grant_m;
  int         owner_m;
  bit         vld_m;
  int         hold_m;
  logic [7:0] shadow_m, frame_m;

  always @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      pos_m = -1; grant_m = 4'b0; owner_m = 0; vld_m = 0;
      hold_m = 0; shadow_m = 8'h00; frame_m = 8'h00;
    end else begin
      int win;
      int start;
      pos_m++;
      if (pos_m % FRAME == 0) frame_m = shadow_m;
      win = -1;
      if (hold_m == 0) begin
        start = vld_m ? owner_m + 1 : 0;
        for (int k = 0; k < 4; k++)
          if (win < 0 && i_req[(start + k) % 4]) win = (start + k) % 4;
      end else if (i_req[owner_m]) begin
        win = owner_m;
      end
      grant_m = 4'b0;
      if (win >= 0) begin
        grant_m[win] = 1'b1;
        owner_m  = win;
        vld_m    = 1;
        shadow_m = i_data[8*win +: 8];
        hold_m   = HOLD;
      end else if (hold_m > 0) begin
        hold_m--;
      end
    end
  end

  function automatic logic [6:0] exp_seg();
    int ph;
    if (pos_m < 0) return 7'h00;
    ph = pos_m % FRAME;
    if (ph < DWELL) return hex7(frame_m[3:0]);
    if (ph < DWELL + BLANK) return 7'h00;
    if (ph < 2 * DWELL + BLANK) begin
`ifdef NIXIE_LEADING_ZERO_BLANK_EN
      if (frame_m[7:4] == 4'h0) return 7'h00;
`endif
      return hex7(frame_m[7:4]);
    end
    return 7'h00;
  endfunction

  function automatic logic exp_sel();
    if (pos_m < 0) return 1'b0;
    return (pos_m % FRAME) >= DWELL + BLANK;
  endfunction

  always @(posedge i_clk) begin
    #1;
    chk("grant", 32'(o_grant), 32'(grant_m));
    chk("owner", 32'(o_owner), 32'(owner_m));
    chk("segments", 32'(o_nixieTube), 32'(exp_seg()));
    chk("sel", 32'(o_sel), 32'(exp_sel()));
  end

  task automatic wait_grant(output int idx, output int at);
    idx = -1;
    at  = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge i_clk); #1;
      if (o_grant != 4'b0) begin
        at = tb_cyc;
        for (int b = 0; b < 4; b++) if (o_grant[b]) idx = b;
        break;
      end
    end
    chk("grant_wait", 32'(idx >= 0), 32'd1);
  endtask

  task automatic wait_frame();
    bit found = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge i_clk); #1;
      if (pos_m > 0 && pos_m % FRAME == 0) begin
        found = 1;
        break;
      end
    end
    chk("frame_wait", 32'(found), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int g, t0, t1;
    int order [3] = '{3, 0, 1};
    int bitn;

    // Reset state
    #1;
    chk("rst_seg", 32'(o_nixieTube), 32'h00);
    chk("rst_sel", 32'(o_sel), 32'h0);
    chk("rst_grant", 32'(o_grant), 32'h0);
    chk("rst_owner", 32'(o_owner), 32'h0);

    // First grant and first displayed value
    @(negedge i_clk); @(negedge i_clk);
    i_rst  = 1'b1;
    i_data = 32'h003A_0000;
    i_req  = 4'b0100;
    @(posedge i_clk); #1;
    chk("t2_grant", 32'(o_grant), 32'h4);
    chk("t2_owner", 32'(o_owner), 32'h2);
    chk("first_dig0", 32'(o_nixieTube), 32'h3F);
    @(negedge i_clk) i_req = 4'b0;
    wait_frame();
    chk("t2_lo", 32'(o_nixieTube), 32'h77);
    chk("t2_lo_sel", 32'(o_sel), 32'h0);
    for (int k = 1; k <= 10; k++) begin
      @(posedge i_clk); #1;
      if (k < 8) chk("t2_lo_dwell", 32'(o_nixieTube), 32'h77);
      else if (k < 10) chk("t2_blank", 32'(o_nixieTube), 32'h00);
      else begin
        chk("t2_hi", 32'(o_nixieTube), 32'h4F);
        chk("t2_hi_sel", 32'(o_sel), 32'h1);
      end
    end

    // Other request waits for the hold to expire
    @(negedge i_clk) i_req = 4'b0100;
    wait_grant(g, t0);
    chk("t3_first", 32'(g), 32'd2);
    @(negedge i_clk);
    i_req  = 4'b0;
    i_data = 32'h0000_5C00;
    repeat (4) @(negedge i_clk);
    i_req = 4'b0010;
    wait_grant(g, t1);
    chk("t3_winner", 32'(g), 32'd1);
    chk("t3_spacing", 32'(t1 - t0), 32'(HOLD + 1));
    @(negedge i_clk) i_req = 4'b0;

    // Round-robin order after owner 2
    repeat (25) @(negedge i_clk);
    i_req = 4'b0100;
    wait_grant(g, t0);
    chk("t4_own2", 32'(g), 32'd2);
    @(negedge i_clk) i_req = 4'b0;
    repeat (25) @(negedge i_clk);
    i_data = $urandom;
    i_req  = 4'b1011;
    for (int n = 0; n < 3; n++) begin
      wait_grant(g, t1);
      chk("t4_order", 32'(g), 32'(order[n]));
      if (n > 0) chk("t4_spacing", 32'(t1 - t0), 32'(HOLD + 1));
      t0 = t1;
      @(negedge i_clk);
      if (g >= 0) i_req[g] = 1'b0;
    end
    i_req = 4'b0;

    // Owner re-latch during hold; display updates at next frame
    repeat (25) @(negedge i_clk);
    i_data = 32'h0000_0077;
    i_req  = 4'b0001;
    wait_grant(g, t0);
    chk("t5_own0", 32'(g), 32'd0);
    @(negedge i_clk) i_req = 4'b0;
    repeat (4) @(negedge i_clk);
    i_data = 32'h0000_0005;
    i_req  = 4'b0001;
    @(posedge i_clk); #1;
    chk("t5_relatch", 32'(o_grant), 32'h1);
    @(negedge i_clk) i_req = 4'b0;
    wait_frame();
    chk("t5_lo", 32'(o_nixieTube), 32'h6D);
    repeat (10) @(posedge i_clk);
    #1;
    chk("t5_hi", 32'(o_nixieTube), 32'(HI_ZERO));
    chk("t5_hi_sel", 32'(o_sel), 32'h1);

    // Reset mid-dwell with owner 2
    repeat (25) @(negedge i_clk);
    i_req = 4'b0100;
    wait_grant(g, t0);
    chk("t6_own2", 32'(g), 32'd2);
    @(negedge i_clk) i_req = 4'b0;
    wait_frame();
    repeat (3) @(posedge i_clk);
    @(negedge i_clk) i_rst = 1'b0;
    #1;
    chk("t6_seg", 32'(o_nixieTube), 32'h00);
    chk("t6_sel", 32'(o_sel), 32'h0);
    chk("t6_grant", 32'(o_grant), 32'h0);
    chk("t6_owner", 32'(o_owner), 32'h0);
    @(negedge i_clk);
    @(negedge i_clk) i_rst = 1'b1;
    for (int k = 0; k < DWELL; k++) begin
      @(posedge i_clk); #1;
      chk("t6_dig0", 32'(o_nixieTube), 32'h3F);
    end

    // Random traffic against the model
    for (int c = 0; c < 800; c++) begin
      @(negedge i_clk);
      i_data = $urandom;
      if ($urandom_range(0, 5) == 0) begin
        bitn = $urandom_range(0, 3);
        i_req[bitn] = ~i_req[bitn];
      end
    end
    i_req = 4'b0;
    repeat (3) @(negedge i_clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
